// File: rtl/time_register_if.sv
// rtl/time_register_if.sv - strobe/button inputs and time-of-day outputs of time_register
interface time_register_if;
  logic       i_1hz_stb;
  logic       i_slow_set_stb;
  logic       i_fast_set_stb;
  logic       i_set_hr;
  logic       i_set_min;
  logic [4:0] o_hours;
  logic [5:0] o_minutes;
  logic [5:0] o_seconds;
  logic       o_setting;

  modport master (
    output i_1hz_stb, i_slow_set_stb, i_fast_set_stb, i_set_hr, i_set_min,
    input  o_hours, o_minutes, o_seconds, o_setting
  );

  modport slave (
    input  i_1hz_stb, i_slow_set_stb, i_fast_set_stb, i_set_hr, i_set_min,
    output o_hours, o_minutes, o_seconds, o_setting
  );
endinterface

// File: rtl/time_register.sv
// rtl/time_register.sv - 24h time-of-day counter with press-and-hold slow/fast setting
module time_register #(
  parameter int FAST_HOLD = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  time_register_if.slave bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_SET_SLOW = 2'd1;
  localparam logic [1:0] ST_SET_FAST = 2'd2;
  localparam logic [3:0] FAST_HOLD_C = 4'(FAST_HOLD);

  logic [1:0] state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       sel_hr_q, sel_hr_d;
  logic [4:0] hours_q, hours_d;
  logic [5:0] minutes_q, minutes_d;
  logic [5:0] seconds_q, seconds_d;

  logic       sel_hr, sel_min, sel_any, sel_same;
  logic       step_en, step_hr;
  logic [3:0] hold_inc;

  assign sel_hr   = bus.i_set_hr & ~bus.i_set_min;
  assign sel_min  = bus.i_set_min & ~bus.i_set_hr;
  assign sel_any  = sel_hr | sel_min;
  // A swap from one button to the other in a single cycle must look like a release.
  assign sel_same = sel_hr_q ? sel_hr : sel_min;
  assign hold_inc = hold_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    sel_hr_d  = sel_hr_q;
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    step_en   = 1'b0;
    step_hr   = sel_hr_q;

    case (state_q)
      ST_RUN: begin
        if (sel_any) begin
          state_d   = ST_SET_SLOW;
          sel_hr_d  = sel_hr;
          hold_d    = 4'd0;
          seconds_d = 6'd0;
          step_en   = 1'b1;
          step_hr   = sel_hr;
        end else if (bus.i_1hz_stb) begin
          if (seconds_q == 6'd59) begin
            seconds_d = 6'd0;
            if (minutes_q == 6'd59) begin
              minutes_d = 6'd0;
              hours_d   = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end
      end
      ST_SET_SLOW: begin
        if (!sel_same) begin
          state_d = ST_RUN;
          hold_d  = 4'd0;
        end else begin
          seconds_d = 6'd0;
          if (bus.i_slow_set_stb) begin
            step_en = 1'b1;
            hold_d  = hold_inc;
            if (hold_inc == FAST_HOLD_C) begin
              state_d = ST_SET_FAST;
            end
          end
        end
      end
      ST_SET_FAST: begin
        if (!sel_same) begin
          state_d = ST_RUN;
          hold_d  = 4'd0;
        end else begin
          seconds_d = 6'd0;
          step_en   = bus.i_fast_set_stb;
        end
      end
      default: begin
        state_d = ST_RUN;
        hold_d  = 4'd0;
      end
    endcase

    // Set steps wrap within their own field; minutes never carry into hours.
    if (step_en) begin
      if (step_hr) begin
        hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
      end else begin
        minutes_d = (minutes_q == 6'd59) ? 6'd0 : minutes_q + 6'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_RUN;
      hold_q    <= 4'd0;
      sel_hr_q  <= 1'b0;
      hours_q   <= 5'd0;
      minutes_q <= 6'd0;
      seconds_q <= 6'd0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      sel_hr_q  <= sel_hr_d;
      hours_q   <= hours_d;
      minutes_q <= minutes_d;
      seconds_q <= seconds_d;
    end
  end

  assign bus.o_hours   = hours_q;
  assign bus.o_minutes = minutes_q;
  assign bus.o_seconds = seconds_q;
  assign bus.o_setting = (state_q == ST_SET_SLOW) || (state_q == ST_SET_FAST);

endmodule

// File: tb/tb_time_register.sv
// tb/tb_time_register.sv - directed self-checking bench for time_register
module tb_time_register;
  localparam int FAST_HOLD = 4;

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_checks = 0;
  int   n_errors = 0;

  time_register_if tr_if ();

  time_register #(.FAST_HOLD(FAST_HOLD)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (tr_if.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed != expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hours"},   int'(tr_if.o_hours),   h);
    check({tag, ".minutes"}, int'(tr_if.o_minutes), m);
    check({tag, ".seconds"}, int'(tr_if.o_seconds), s);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      tr_if.i_1hz_stb = 1'b1;
      cyc();
      tr_if.i_1hz_stb = 1'b0;
    end
  endtask

  task automatic slow_pulse();
    tr_if.i_slow_set_stb = 1'b1;
    cyc();
    tr_if.i_slow_set_stb = 1'b0;
  endtask

  task automatic fast_pulse();
    tr_if.i_fast_set_stb = 1'b1;
    cyc();
    tr_if.i_fast_set_stb = 1'b0;
  endtask

  task automatic release_buttons();
    tr_if.i_set_hr  = 1'b0;
    tr_if.i_set_min = 1'b0;
    cyc();
  endtask

  // Advance a field by n steps: entry step, FAST_HOLD slow steps, then fast steps.
  task automatic set_field(input bit hr, input int n);
    if (n > 0) begin
      tr_if.i_set_hr  = hr;
      tr_if.i_set_min = ~hr;
      cyc();
      for (int i = 1; i < n; i++) begin
        if (i <= FAST_HOLD) slow_pulse();
        else                fast_pulse();
      end
      release_buttons();
    end
  endtask

  initial begin
    bit seen_setting;

    i_reset              = 1'b1;
    tr_if.i_1hz_stb      = 1'b0;
    tr_if.i_slow_set_stb = 1'b0;
    tr_if.i_fast_set_stb = 1'b0;
    tr_if.i_set_hr       = 1'b0;
    tr_if.i_set_min      = 1'b0;
    cyc();
    cyc();
    i_reset = 1'b0;
    check_time("reset", 0, 0, 0);
    check("reset.setting", int'(tr_if.o_setting), 0);

    // 61 seconds of plain counting
    seen_setting = 1'b0;
    for (int i = 0; i < 61; i++) begin
      tick(1);
      if (tr_if.o_setting) seen_setting = 1'b1;
    end
    check_time("count61", 0, 1, 1);
    check("count61.setting_seen", int'(seen_setting), 0);

    // Full-day rollover
    do_reset();
    set_field(1'b1, 23);
    set_field(1'b0, 59);
    check("preload.setting", int'(tr_if.o_setting), 0);
    tick(58);
    check_time("preload", 23, 59, 58);
    tick(1);
    check_time("rollover_a", 23, 59, 59);
    tick(1);
    check_time("rollover_b", 0, 0, 0);

    // Minute setting from 10:20:33 with slow-to-fast acceleration
    do_reset();
    set_field(1'b1, 10);
    set_field(1'b0, 20);
    tick(33);
    check_time("pre_set", 10, 20, 33);
    tr_if.i_set_min = 1'b1;
    cyc();
    check_time("entry", 10, 21, 0);
    check("entry.setting", int'(tr_if.o_setting), 1);
    for (int i = 0; i < 4; i++) begin
      slow_pulse();
      cyc();
    end
    check_time("slow4", 10, 25, 0);
    fast_pulse();
    slow_pulse();
    check("fast_ignores_slow", int'(tr_if.o_minutes), 26);
    fast_pulse();
    tick(1);
    fast_pulse();
    check_time("fast3", 10, 28, 0);
    release_buttons();
    check("release.setting", int'(tr_if.o_setting), 0);
    check_time("release", 10, 28, 0);
    cyc();
    tick(1);
    check_time("resume", 10, 28, 1);

    // Hour wrap 22 -> 23 -> 0 -> 1 with minutes untouched
    do_reset();
    set_field(1'b1, 22);
    set_field(1'b0, 7);
    tr_if.i_set_hr = 1'b1;
    cyc();
    check("hr_entry", int'(tr_if.o_hours), 23);
    slow_pulse();
    check("hr_wrap", int'(tr_if.o_hours), 0);
    slow_pulse();
    check_time("hr_after", 1, 7, 0);
    release_buttons();

    // Minute wrap without carry
    do_reset();
    set_field(1'b1, 5);
    set_field(1'b0, 59);
    tr_if.i_set_min = 1'b1;
    cyc();
    check_time("min_wrap", 5, 0, 0);

    // Strobe in the release cycle is not applied
    tr_if.i_set_min      = 1'b0;
    tr_if.i_slow_set_stb = 1'b1;
    cyc();
    tr_if.i_slow_set_stb = 1'b0;
    check_time("release_strobe", 5, 0, 0);

    // Both buttons held: no selection, counting continues
    tr_if.i_set_hr  = 1'b1;
    tr_if.i_set_min = 1'b1;
    slow_pulse();
    tick(1);
    check_time("both", 5, 0, 1);
    check("both.setting", int'(tr_if.o_setting), 0);
    release_buttons();

    // Tick coincident with press is dropped; coincident set strobe gives one step only
    tick(2);
    tr_if.i_set_min      = 1'b1;
    tr_if.i_1hz_stb      = 1'b1;
    tr_if.i_slow_set_stb = 1'b1;
    cyc();
    tr_if.i_1hz_stb      = 1'b0;
    tr_if.i_slow_set_stb = 1'b0;
    check_time("press_tick", 5, 1, 0);

    // Selection swap acts as release, then re-entry
    tr_if.i_set_min = 1'b0;
    tr_if.i_set_hr  = 1'b1;
    cyc();
    check("swap.setting", int'(tr_if.o_setting), 0);
    check_time("swap", 5, 1, 0);
    cyc();
    check("reenter.setting", int'(tr_if.o_setting), 1);
    check("reenter.hours", int'(tr_if.o_hours), 6);
    release_buttons();

    // Reset mid SET_FAST with button still held
    tr_if.i_set_min = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) slow_pulse();
    fast_pulse();
    check("prefast.minutes", int'(tr_if.o_minutes), 7);
    do_reset();
    check_time("mid_reset", 0, 0, 0);
    check("mid_reset.setting", int'(tr_if.o_setting), 0);
    cyc();
    check("post_reset.setting", int'(tr_if.o_setting), 1);
    check_time("post_reset", 0, 1, 0);
    release_buttons();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/time_register.md
Name: time_register

Overview:
- Time-of-day counter directly downstream of the strobe generator.
- Consumes the 1 Hz, slow-set (2 Hz) and fast-set (8 Hz) strobes, plus debounced set-button levels from the input stage.
- Keeps 24-hour binary hours/minutes/seconds and applies press-and-hold time setting with slow-to-fast acceleration.
- Outputs feed the display/BCD conversion stage.

Parameters:
- FAST_HOLD, 4: number of slow-set strobes seen while a set button is held before stepping switches to fast-set strobes. Legal range 1..15.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_1hz_stb  input  1  one-cycle pulse at 1 Hz.
- i_slow_set_stb  input  1  one-cycle pulse at 2 Hz.
- i_fast_set_stb  input  1  one-cycle pulse at 8 Hz.
- i_set_hr  input  1  debounced level; high while the hour-set button is held.
- i_set_min  input  1  debounced level; high while the minute-set button is held.
- o_hours  output  5  hours, 0..23.
- o_minutes  output  6  minutes, 0..59.
- o_seconds  output  6  seconds, 0..59.
- o_setting  output  1  high while the FSM is in SET_SLOW or SET_FAST.

Behaviour:
- Reset (i_reset high at a clock edge) has priority over everything else in that cycle:
  - o_hours, o_minutes, o_seconds = 0.
  - FSM = RUN; hold counter = 0; o_setting = 0.
- Registered outputs only. Every update is visible one cycle after the qualifying input edge.
- sel_hr = i_set_hr & ~i_set_min; sel_min = i_set_min & ~i_set_hr. Both buttons held counts as neither selected.
- RUN state:
  - On i_1hz_stb: seconds+1.
  - seconds 59 -> 0 with minutes+1.
  - minutes 59 with seconds 59 -> minutes 0 with hours+1.
  - 23:59:59 -> 00:00:00.
  - Set strobes are ignored.
  - If sel_hr or sel_min is high: go to SET_SLOW. In that same edge, step the selected field once (immediate press-to-step), set seconds to 0, and clear the hold counter. This takes priority over a coincident i_1hz_stb; the tick is dropped.
- SET_SLOW state:
  - i_1hz_stb is ignored; seconds are held at 0.
  - Each i_slow_set_stb steps the selected field and increments the hold counter.
  - When the hold counter reaches FAST_HOLD (on that same strobe), go to SET_FAST.
- SET_FAST state:
  - Seconds are held at 0.
  - Each i_fast_set_stb steps the selected field.
  - i_slow_set_stb is ignored.
- Step rules:
  - Hours: 23 -> 0.
  - Minutes: 59 -> 0, with no carry into hours.
  - Hours and minutes never step in the same cycle.
- Leaving set mode:
  - In SET_SLOW or SET_FAST, if neither sel_hr nor sel_min is high: go to RUN, clear the hold counter, perform no step that cycle. Counting resumes on the next i_1hz_stb.
  - A selection change while setting (hr released, min pressed, same cycle): treated as release. Go to RUN; the new press re-enters SET_SLOW the following cycle.
- Strobe-cycle precedence:
  - A strobe in the cycle the button releases is not applied.
  - A set strobe in the cycle the button is first pressed produces only the single entry step.
- Mid-operation reset: reset in any state returns to 00:00:00 RUN.
  - If a button is still held when reset deasserts, the FSM enters SET_SLOW on the first non-reset edge and applies the entry step.
- o_setting = 1 exactly in SET_SLOW and SET_FAST.
- Out-of-range values cannot occur; arithmetic wraps explicitly, not by width overflow.

Test Plan:
- Reset, then 61 i_1hz_stb pulses -> 00:01:01; o_setting = 0 throughout.
- Preload to 23:59:58 via the set sequence, then 2 i_1hz_stb -> 23:59:59, then 00:00:00.
- From 10:20:33, assert i_set_min and keep it high:
  - Next cycle -> 10:21:00, o_setting = 1.
  - 4 i_slow_set_stb -> 10:25:00, state SET_FAST.
  - 3 i_fast_set_stb -> 10:28:00; an interleaved i_slow_set_stb has no effect.
  - Release -> RUN; next i_1hz_stb -> 10:28:01.
- Hour wrap: at 22:xx, hold i_set_hr through entry plus 2 slow strobes -> hours 22 -> 23 -> 0 -> 1; minutes unchanged.
- Minute wrap without carry: from 05:59:00, hold i_set_min -> 05:00:00.
- Edge cases:
  - Both buttons pressed -> no change; i_1hz_stb still counts.
  - i_1hz_stb coincident with button press -> tick dropped, seconds = 0.
  - i_reset pulsed mid SET_FAST -> 00:00:00, RUN.
